// File: rtl/warp_pkg.sv
// Shared types and limits for the warp engine memory subsystem.
package warp_pkg;

   localparam int TCM_MAX_READ_LATENCY = 4;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } tcm_resp_t;

endpackage

// File: rtl/warp_sync_fifo.sv
// Synchronous FIFO with occupancy count. The head entry is read straight out
// of the storage registers, so it holds steady until popped. Data output is
// forced to zero while empty.
module warp_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;

   assign w_pop = i_pop && (r_count != '0);

   // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (i_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!i_push && w_pop) r_count <= r_count - (AW+1)'(1);
      end
   end

   // Entry storage; contents need no reset because the count qualifies them.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/warp_tcm.sv
// Tightly-coupled memory for one warp engine: word array with host preload,
// READ_LATENCY-cycle read path, credit-limited response FIFO, fault detection.
// Optional build macro WARP_TCM_STATS_EN enables the rd_count/wr_count
// request counters; without it both ports read as zero.
module warp_tcm
   import warp_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int DEPTH           = 1024,
   parameter int READ_LATENCY    = 1,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_req_valid,
   output logic                     mem_req_ready,
   input  logic [ADDR_WIDTH-1:0]    mem_req_addr,
   input  logic                     mem_req_write,
   input  logic [DATA_WIDTH-1:0]    mem_req_data,
   output logic                     mem_resp_valid,
   input  logic                     mem_resp_ready,
   output logic [DATA_WIDTH-1:0]    mem_resp_data,
   output logic                     mem_resp_err,
   input  logic                     ld_valid,
   input  logic [$clog2(DEPTH)-1:0] ld_index,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   output logic                     wr_err,
   output logic [15:0]              rd_count,
   output logic [15:0]              wr_count
);

   localparam int IW   = $clog2(DEPTH);
   localparam int CW   = $clog2(RESP_FIFO_DEPTH);
   // Registered stages between the array read and the FIFO push. With a
   // latency of 1 the array read feeds the FIFO directly and the single
   // declared stage is unused.
   localparam int NSTG = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   tcm_resp_t             r_pipe [NSTG];
   logic                  r_wr_err;

   logic [IW-1:0]         w_idx;
   logic                  w_fault;
   logic                  w_accept;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_credit_ok;
   logic [CW+1:0]         w_used;
   tcm_resp_t             w_stage0;
   tcm_resp_t             w_push_ent;
   logic [CW:0]           w_fifo_count;
   logic                  w_fifo_valid;
   logic [32:0]           w_fifo_dout;

   assign w_idx   = mem_req_addr[IW+1:2];
   assign w_fault = (mem_req_addr[1:0] != 2'b00) ||
                    (mem_req_addr[ADDR_WIDTH-1:IW+2] != '0);

   // Credits: FIFO occupancy plus reads still travelling through the stages.
   // Depends only on registered state, so a pop frees a credit one cycle later.
   always_comb begin
      w_used = {1'b0, w_fifo_count};
      for (int i = 0; i < NSTG; i++) begin
         if (i < READ_LATENCY - 1) w_used = w_used + (CW+2)'(r_pipe[i].valid);
      end
      w_credit_ok = (w_used < (CW+2)'(RESP_FIFO_DEPTH));
   end

   assign mem_req_ready = !rst && !ld_valid && w_credit_ok;
   assign w_accept      = mem_req_valid && mem_req_ready;
   assign w_rd_acc      = w_accept && !mem_req_write;
   assign w_wr_acc      = w_accept && mem_req_write;

   // Array read on the accept cycle; faulting reads carry zero data.
   always_comb begin
      w_stage0.valid = w_rd_acc;
      w_stage0.err   = w_fault;
      w_stage0.data  = w_fault ? '0 : r_mem[w_idx];
   end

   // Read pipeline: payload shifts freely, only the valid bits are reset.
   always_ff @(posedge clk) begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < NSTG; i++) r_pipe[i] <= r_pipe[i-1];
      if (rst) begin
         for (int i = 0; i < NSTG; i++) r_pipe[i].valid <= 1'b0;
      end
   end

   assign w_push_ent = (READ_LATENCY == 1) ? w_stage0 : r_pipe[NSTG-1];

   warp_sync_fifo #(
      .WIDTH (33),
      .DEPTH (RESP_FIFO_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_ent.valid),
      .i_data  ({w_push_ent.err, w_push_ent.data}),
      .i_pop   (mem_resp_ready),
      .o_valid (w_fifo_valid),
      .o_data  (w_fifo_dout),
      .o_count (w_fifo_count)
   );

   assign mem_resp_valid = w_fifo_valid;
   assign mem_resp_err   = w_fifo_dout[32];
   assign mem_resp_data  = w_fifo_dout[31:0];

   // Single write port: preload wins, otherwise a clean accepted write commits.
   always_ff @(posedge clk) begin
      if (ld_valid)                    r_mem[ld_index] <= ld_data;
      else if (w_wr_acc && !w_fault)   r_mem[w_idx]    <= mem_req_data;
   end

   // Sticky write-fault flag.
   always_ff @(posedge clk) begin
      if (rst)                       r_wr_err <= 1'b0;
      else if (w_wr_acc && w_fault)  r_wr_err <= 1'b1;
   end

   assign wr_err = r_wr_err;

`ifdef WARP_TCM_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   // Accepted-request counters, faulting requests included; wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_rd_acc) r_rd_count <= r_rd_count + 16'd1;
         if (w_wr_acc) r_wr_count <= r_wr_count + 16'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif

endmodule

// File: tb/tb_warp_tcm.sv
// Directed bench for warp_tcm (READ_LATENCY=3, RESP_FIFO_DEPTH=4, DEPTH=1024).
module tb_warp_tcm;

   localparam int LAT   = 3;
   localparam int FD    = 4;
   localparam int DEPTH = 1024;

`ifdef WARP_TCM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_write;
   logic [31:0] mem_req_data;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        ld_valid;
   logic [9:0]  ld_index;
   logic [31:0] ld_data;
   logic        wr_err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   warp_tcm #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (32),
      .DEPTH           (DEPTH),
      .READ_LATENCY    (LAT),
      .RESP_FIFO_DEPTH (FD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_write  (mem_req_write),
      .mem_req_data   (mem_req_data),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .ld_valid       (ld_valid),
      .ld_index       (ld_index),
      .ld_data        (ld_data),
      .wr_err         (wr_err),
      .rd_count       (rd_count),
      .wr_count       (wr_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Response and read-accept monitors, sampled on the falling edge.
   logic [32:0] rq[$];
   int          rcyc[$];
   int          acyc[$];

   always @(negedge clk) begin
      if (mem_resp_valid && mem_resp_ready) begin
         rq.push_back({mem_resp_err, mem_resp_data});
         rcyc.push_back(cyc);
      end
      if (mem_req_valid && mem_req_ready && !mem_req_write) acyc.push_back(cyc);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      rq.delete();
      rcyc.delete();
      acyc.delete();
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] d);
      ld_valid = 1'b1;
      ld_index = idx;
      ld_data  = d;
      step();
      ld_valid = 1'b0;
   endtask

   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] d);
      logic ok;
      ok            = 1'b0;
      mem_req_valid = 1'b1;
      mem_req_write = wr;
      mem_req_addr  = addr;
      mem_req_data  = d;
      for (int t = 0; t < 40 && !ok; t++) begin
         #1;
         ok = mem_req_ready;
         @(posedge clk);
         #1;
      end
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      if (!ok) check("req_accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_resp(input int n);
      for (int t = 0; t < 40 && rq.size() < n; t++) step();
   endtask

   logic [31:0] pre_d [6];
   int          acc_n;
   logic        acc;

   initial begin
      pre_d = '{32'd10, 32'd20, 32'd30, 32'd200, 32'd20, 32'd10};
      rst = 1'b1;
      mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_write = 1'b0; mem_req_data = '0;
      mem_resp_ready = 1'b0; ld_valid = 1'b0; ld_index = '0; ld_data = '0;
      step();
      step();

      // Reset state
      check("rst_req_ready", 32'(mem_req_ready), 32'd0);
      check("rst_resp_valid", 32'(mem_resp_valid), 32'd0);
      check("rst_resp_data", mem_resp_data, 32'd0);
      check("rst_resp_err", 32'(mem_resp_err), 32'd0);
      check("rst_wr_err", 32'(wr_err), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);

      // Kernel preload while held in reset
      for (int i = 0; i < 6; i++) preload(10'(i), pre_d[i]);
      preload(10'd1023, 32'h1234);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(mem_req_ready), 32'd1);

      // Streaming reads with the consumer always ready
      mem_resp_ready = 1'b1;
      clear_q();
      for (int i = 0; i < 6; i++) do_req(1'b0, 32'(i * 4), 32'd0);
      wait_resp(6);
      check("stream_count", 32'(rq.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < rq.size() && i < acyc.size()) begin
            check("stream_data", rq[i][31:0], pre_d[i]);
            check("stream_err", 32'(rq[i][32]), 32'd0);
            check("stream_latency", 32'(rcyc[i] - acyc[i]), 32'(LAT));
         end
      end
      check("stream_rd_count", 32'(rd_count), STATS ? 32'd6 : 32'd0);

      // Backpressure: credits stop acceptance at the FIFO depth
      mem_resp_ready = 1'b0;
      clear_q();
      acc_n = 0;
      mem_req_valid = 1'b1;
      mem_req_write = 1'b0;
      for (int c = 0; c < 8; c++) begin
         mem_req_addr = 32'(acc_n * 4);
         #1;
         acc = mem_req_ready;
         @(posedge clk);
         #1;
         if (acc) acc_n++;
      end
      mem_req_valid = 1'b0;
      check("bp_accepted", 32'(acc_n), 32'(FD));
      check("bp_ready_low", 32'(mem_req_ready), 32'd0);
      check("bp_head_valid", 32'(mem_resp_valid), 32'd1);
      check("bp_head_data", mem_resp_data, 32'd10);
      step();
      check("bp_head_hold", mem_resp_data, 32'd10);
      mem_resp_ready = 1'b1;
      wait_resp(4);
      check("bp_drain_count", 32'(rq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < rq.size()) check("bp_drain_data", rq[i][31:0], pre_d[i]);
      end
      step();
      check("bp_ready_back", 32'(mem_req_ready), 32'd1);

      // Write then read on the very next cycle
      clear_q();
      do_req(1'b1, 32'h40, 32'hDEADBEEF);
      do_req(1'b0, 32'h40, 32'd0);
      wait_resp(1);
      check("raw_data", rq.size() > 0 ? rq[0][31:0] : 32'hFFFF_FFFF, 32'hDEADBEEF);

      // Faulting reads, last valid word, faulting write
      clear_q();
      check("flt_wr_err_before", 32'(wr_err), 32'd0);
      do_req(1'b0, 32'h2, 32'd0);
      do_req(1'b0, 32'h1000, 32'd0);
      do_req(1'b0, 32'hFFC, 32'd0);
      wait_resp(3);
      check("flt_count", 32'(rq.size()), 32'd3);
      if (rq.size() >= 3) begin
         check("flt_mis_err", 32'(rq[0][32]), 32'd1);
         check("flt_mis_data", rq[0][31:0], 32'd0);
         check("flt_oor_err", 32'(rq[1][32]), 32'd1);
         check("flt_oor_data", rq[1][31:0], 32'd0);
         check("last_word_err", 32'(rq[2][32]), 32'd0);
         check("last_word_data", rq[2][31:0], 32'h1234);
      end
      do_req(1'b1, 32'h1000, 32'h55);
      step();
      check("flt_wr_err", 32'(wr_err), 32'd1);
      clear_q();
      do_req(1'b0, 32'h0, 32'd0);
      wait_resp(1);
      check("flt_wr_dropped", rq.size() > 0 ? rq[0][31:0] : 32'hFFFF_FFFF, 32'd10);

      // Preload collides with a request
      clear_q();
      mem_req_valid = 1'b1;
      mem_req_write = 1'b0;
      mem_req_addr  = 32'h1C;
      ld_valid = 1'b1;
      ld_index = 10'd7;
      ld_data  = 32'h77;
      #1;
      check("ld_blocks_ready", 32'(mem_req_ready), 32'd0);
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      #1;
      check("ld_ready_next", 32'(mem_req_ready), 32'd1);
      @(posedge clk);
      #1;
      mem_req_valid = 1'b0;
      wait_resp(1);
      check("ld_readback", rq.size() > 0 ? rq[0][31:0] : 32'hFFFF_FFFF, 32'h77);

      check("total_rd_count", 32'(rd_count), STATS ? 32'd16 : 32'd0);
      check("total_wr_count", 32'(wr_count), STATS ? 32'd2 : 32'd0);

      // Reset with reads in flight
      mem_resp_ready = 1'b0;
      do_req(1'b0, 32'h40, 32'd0);
      do_req(1'b0, 32'h0, 32'd0);
      do_req(1'b0, 32'h4, 32'd0);
      rst = 1'b1;
      step();
      step();
      check("flush_valid_in_rst", 32'(mem_resp_valid), 32'd0);
      rst = 1'b0;
      clear_q();
      mem_resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check("flush_no_resp", 32'(rq.size()), 32'd0);
      check("flush_rd_count", 32'(rd_count), 32'd0);
      check("flush_wr_count", 32'(wr_count), 32'd0);
      check("flush_wr_err", 32'(wr_err), 32'd0);
      do_req(1'b0, 32'h40, 32'd0);
      wait_resp(1);
      check("flush_keeps_array", rq.size() > 0 ? rq[0][31:0] : 32'hFFFF_FFFF, 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/warp_tcm.md
# warp_tcm

Parametrised, synthesizable tightly-coupled memory that serves the warp engine's `mem_req`/`mem_resp` port, replacing the fixed 1-cycle, always-ready behavioural memory used in integration benches. It provides configurable depth and read latency, a credit-limited response FIFO so that `mem_resp_ready` backpressure is honoured, out-of-range and misalignment detection, and a host preload port for loading kernels. It sits between `warp_engine` and the SoC, one instance per engine.

## Interface
- `DATA_WIDTH`, 32: word width in bits. Only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `DEPTH`, 1024: number of words. Must be a power of 2 and ≥ 16.
- `READ_LATENCY`, 1: cycles from read accept to `mem_resp_valid`. Range 1..4.
- `RESP_FIFO_DEPTH`, 4: response FIFO entries. Must be a power of 2 and ≥ `READ_LATENCY`+1.

Clock and reset are fixed: one clock; reset is synchronous and active-high.

Ports:
- `clk` in, 1: sole clock. All logic uses the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `mem_req_valid` in, 1: request valid.
- `mem_req_ready` out, 1: request accepted when both `mem_req_valid` and `mem_req_ready` are high.
- `mem_req_addr` in, `ADDR_WIDTH`: byte address.
- `mem_req_write` in, 1: 1 = write, 0 = read.
- `mem_req_data` in, `DATA_WIDTH`: write data.
- `mem_resp_valid` out, 1: read response valid.
- `mem_resp_ready` in, 1: consumer ready for a response.
- `mem_resp_data` out, `DATA_WIDTH`: read data.
- `mem_resp_err` out, 1: the response belongs to a faulting read; `mem_resp_data` is 0.
- `ld_valid` in, 1: host preload write strobe.
- `ld_index` in, `$clog2(DEPTH)`: preload word index.
- `ld_data` in, `DATA_WIDTH`: preload data.
- `wr_err` out, 1: sticky flag, set by any faulting write.
- `rd_count` out, 16: number of reads accepted.
- `wr_count` out, 16: number of writes accepted.

## Operation
**Address decode**
- Word index = `mem_req_addr[$clog2(DEPTH)+1:2]`.
- A request faults if `addr[1:0] != 0` or `addr >= DEPTH*4`.

**Writes**
- A write is committed to the array on the accept edge.
- Writes produce no response.
- A faulting write is dropped and sets `wr_err`.

**Reads**
- An accepted read enters a `READ_LATENCY`-stage pipeline carrying valid, data and err, then is pushed into the response FIFO.
- A faulting read returns `mem_resp_err`=1 and data 0, in order with the other responses.

**Credits**
- `inflight` = reads currently in the pipeline.
- `mem_req_ready` = !`rst` && !`ld_valid` && (`fifo_count` + `inflight` < `RESP_FIFO_DEPTH`).
- Ready does not depend on `mem_req_write`, so writes also stall while credits are exhausted.
- The FIFO therefore never overflows and responses are never dropped.

**Preload**
- `ld_valid` has priority over requests and forces `mem_req_ready` low in the same cycle.
- The preload writes `ld_data` to `ld_index` on that edge.

**Ordering and hazards**
- The array is single-ported; a read and a write can never occur in the same cycle.
- A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Responses are returned strictly in request order.

**Counters**
- `rd_count` and `wr_count` increment on each accepted request, including faulting ones. Preloads are not counted.
- The counters wrap from 0xFFFF to 0.

**Reset**
- Reset flushes the pipeline and the FIFO; in-flight responses are discarded.
- Reset clears `wr_err` and both counters.
- Reset does not clear array contents, so a kernel can be preloaded before reset is released.

## Timing
- Reset values: `mem_req_ready`=0, `mem_resp_valid`=0, `mem_resp_data`=0, `mem_resp_err`=0, `wr_err`=0, `rd_count`=0, `wr_count`=0.
- `mem_req_ready` rises on the first cycle after `rst` deasserts.
- A read accepted at edge N with an empty FIFO produces `mem_resp_valid` in cycle N+`READ_LATENCY`.
- With `READ_LATENCY`=1 this matches the legacy model's timing.
- `mem_resp_valid`, `mem_resp_data` and `mem_resp_err` are driven from the FIFO head register and hold stable while `mem_resp_valid` && !`mem_resp_ready`.
- Push and pop may occur in the same cycle on a full FIFO. The credit check counts the FIFO occupancy before the pop, so `mem_req_ready` reopens one cycle after the pop.
- With `mem_resp_ready` held high, the block sustains one read per cycle.
- The credit logic is registered, giving `mem_req_ready` a one-cycle lag after a FIFO pop; `ld_valid` gates it combinationally.

## Configuration
- Macro: `WARP_TCM_STATS_EN`.
- Defined: `rd_count` and `wr_count` are implemented as described above.
- Undefined: the counter registers are omitted and both ports are tied to 0; all other behaviour is identical.

## Structure
- Shared package `warp_pkg` holds:
  - `typedef struct packed { logic valid; logic err; logic [31:0] data; } tcm_resp_t`
  - `localparam TCM_MAX_READ_LATENCY = 4`
- Sub-module `warp_sync_fifo` (parametrised width and depth; count output) implements the response FIFO.
- The array, pipeline and credit logic live in `warp_tcm`.

## Test plan
- Preload indices 0..5 with 10, 20, 30, 200, 20, 10; reset; read byte addresses 0x0..0x14 with `mem_resp_ready`=1 → data 10, 20, 30, 200, 20, 10 in order. Each response arrives `READ_LATENCY` cycles after its accept. `rd_count`=6.
- `READ_LATENCY`=3, `RESP_FIFO_DEPTH`=4, `mem_resp_ready`=0, back-to-back reads → exactly 4 accepted, then `mem_req_ready`=0. Raise `mem_resp_ready` → 4 responses drain in order with none lost, and `mem_req_ready` reasserts.
- Write 0xDEADBEEF to 0x40 at edge N, then read 0x40 at edge N+1 → returns 0xDEADBEEF.
- Read addresses 0x2 and 0x1000 with `DEPTH`=1024 → two responses with `mem_resp_err`=1 and data 0. Write to 0x1000 → `wr_err`=1 and the array is unchanged.
- Assert `ld_valid` while `mem_req_valid`=1 → `mem_req_ready`=0 that cycle, the preload is written, and the request is accepted the next cycle.
- Assert `rst` with 3 reads in flight → no `mem_resp_valid` afterwards; counters and `wr_err` are 0; previously written data still reads back.
